load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle data-memory access unit between the control FSM/datapath (MEMREAD, MEMWRITE states) and the unified memory. It accepts one load or store request at a time, checks alignment, generates byte enables and replicated write data, and drives a req/ack handshake to memory that tolerates wait states. It returns a load result that is already aligned and sign- or zero-extended, and it bounds each access with a timeout.

## Interface
- `TIMEOUT`, 255: maximum number of ACCESS cycles to wait for `mem_ack`; 0 disables the timeout.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `req_valid` in 1: request strobe from the control FSM.
- `req_ready` out 1: high only in IDLE; a request is accepted on a cycle where `req_valid & req_ready`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- `req_addr` in 32: byte address, normally the ALU result.
- `req_wdata` in 32: store data (rs2).
- `rsp_valid` out 1: one-cycle pulse when the access finishes.
- `rsp_rdata` out 32: extended load data; holds its value until the next response.
- `rsp_misaligned` out 1: response status; valid with `rsp_valid`.
- `rsp_fault` out 1: timeout or illegal funct3; valid with `rsp_valid`.
- `mem_req` out 1: memory request, held until ack.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: replicated store data.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **Reset:** state = IDLE and the timeout counter clears. Outputs: `req_ready`=1; `rsp_valid`, `rsp_misaligned`, `rsp_fault`, `mem_req`, `mem_we` = 0; `rsp_rdata`, `mem_addr`, `mem_wdata` = 0; `mem_be` = 0.
- **IDLE:** on accept, register `write`, `funct3`, `addr`, `wdata`.
  - Illegal funct3 (loads: 3, 6, 7; stores: ≥3) → RESP with `rsp_fault`=1. No memory access.
  - Misaligned access (H with `addr[0]`=1; W with `addr[1:0]`≠0) → RESP with `rsp_misaligned`=1. No memory access.
  - Otherwise → ACCESS.
- **ACCESS:** `mem_req`=1, and `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` stay stable every cycle until ack.
  - `mem_ack` → RESP. For a load, capture the extended data.
  - Without ack, the counter increments. After TIMEOUT ACCESS cycles with no ack → RESP with `rsp_fault`=1, and `mem_req` drops.
  - Ack in the TIMEOUT-th cycle counts as success (ack wins).
- **RESP:** `rsp_valid`=1 for exactly one cycle, then IDLE. Status flags are cleared on the next accept.
- **Byte enables:**
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
  - Loads drive the same enables.
- **Write data:** SB → `{4{wdata[7:0]}}`; SH → `{2{wdata[15:0]}}`; SW → `wdata`.
- **Load data:** shift `mem_rdata` right by `8*addr[1:0]`, then:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- **`rsp_rdata` on store, fault or misaligned responses:** driven to 0.
- **`mem_ack` outside ACCESS:** ignored.
- **`reset` low mid-access:** immediate return to IDLE and `mem_req` drops; any pending response is discarded.

## Timing
- Accept in cycle 0. `mem_req` is high from cycle 1.
- Ack in cycle k (k≥1) → `rsp_valid` in cycle k+1 → `req_ready` high in cycle k+2.
- Minimum latency is accept to `rsp_valid` in 2 cycles, with ack in the first ACCESS cycle.
- Misaligned or illegal requests produce `rsp_valid` in cycle 1.
- Timeout: `rsp_valid` in cycle TIMEOUT+1.
- All outputs are registered or decoded from state only; no combinational path from `mem_ack` or `mem_rdata` to any output.

## Test plan
- **LW with zero wait:** `mem_rdata`=0xdeadbeef, LW at 0x40, ack in the first ACCESS cycle. Required:
  - `mem_addr`=0x40, `mem_be`=1111.
  - `rsp_valid` two cycles after accept, `rsp_rdata`=0xdeadbeef.
- **Byte and halfword loads from 0x43/0x42:** `mem_rdata`=0xcafebabe. Required:
  - LB 0x43 → 0xffffffca.
  - LBU 0x43 → 0x000000ca.
  - LH 0x42 → 0xffffcafe.
  - LHU 0x42 → 0x0000cafe.
- **SB to 0x41 with wait states:** `req_wdata`=0x12345678, ack held off for 3 cycles. Required:
  - `mem_be`=0010, `mem_wdata`=0x78787878, `mem_we`=1, all stable across the 3 wait cycles.
  - `rsp_rdata`=0.
- **Misaligned and illegal requests:** LW at 0x42 and SH at 0x41. Required: `rsp_misaligned`=1 in cycle 1 with `mem_req` never asserted. Load funct3=3 → `rsp_fault`=1.
- **Timeout:** TIMEOUT=4, no ack. Required: `mem_req` high for exactly 4 cycles, then `rsp_fault`=1. Ack in the 4th cycle instead → normal completion.
- **Reset mid-access:** `reset` low while in ACCESS. Required: `mem_req`=0 immediately, `req_ready`=1, no `rsp_valid`. A late `mem_ack` after reset is released is ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundles for the load/store unit: the request/response port toward the
// control FSM, and the req/ack port toward the unified memory.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_fault;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_fault
  );
endinterface

interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: alignment check, byte-enable and store-data
// generation, req/ack memory handshake with timeout, extended load result.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input logic       clk,
  input logic       reset,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  function automatic logic illegal_f3(input logic write, input logic [2:0] f3);
    if (write) return f3 > 3'd2;
    return (f3 == 3'd3) || (f3 > 3'd5);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd1:    return off[0];
      2'd2:    return off != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rep_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'd0:    r = b;
      3'd1:    r = h;
      3'd4:    r = {24'd0, sh[7:0]};
      3'd5:    r = {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  state_t             state, state_nxt;
  logic               accept;
  logic               req_illegal;
  logic               req_misaligned;
  logic               timed_out;
  logic [CNT_W-1:0]   wait_cnt;
  logic [2:0]         f3_p0;
  logic [1:0]         off_p0;
  logic               we_p0;
  logic [31:0]        mem_addr_p0;
  logic [31:0]        mem_wdata_p0;
  logic [3:0]         mem_be_p0;
  logic [31:0]        rsp_rdata_p1;
  logic               rsp_mis_p1;
  logic               rsp_fault_p1;

  assign accept         = req.req_valid && (state == IDLE);
  assign req_illegal    = illegal_f3(req.req_write, req.req_funct3);
  assign req_misaligned = misaligned(req.req_funct3, req.req_addr[1:0]);
  // The TIMEOUT-th waiting cycle is the last one; an ack in it still wins.
  assign timed_out      = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req.req_valid)
                 state_nxt = (req_illegal || req_misaligned) ? RESP : ACCESS;
      ACCESS:  if (mem.mem_ack || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture at accept; response capture on ack or timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt     <= '0;
      f3_p0        <= '0;
      off_p0       <= '0;
      we_p0        <= 1'b0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
      mem_be_p0    <= '0;
      rsp_rdata_p1 <= '0;
      rsp_mis_p1   <= 1'b0;
      rsp_fault_p1 <= 1'b0;
    end else if (accept) begin
      wait_cnt     <= '0;
      f3_p0        <= req.req_funct3;
      off_p0       <= req.req_addr[1:0];
      we_p0        <= req.req_write;
      mem_addr_p0  <= {req.req_addr[31:2], 2'b00};
      mem_wdata_p0 <= rep_wdata(req.req_funct3, req.req_wdata);
      mem_be_p0    <= byte_en(req.req_funct3, req.req_addr[1:0]);
      rsp_fault_p1 <= req_illegal;
      rsp_mis_p1   <= !req_illegal && req_misaligned;
      if (req_illegal || req_misaligned) rsp_rdata_p1 <= '0;
    end else if (state == ACCESS) begin
      if (mem.mem_ack) begin
        rsp_rdata_p1 <= we_p0 ? 32'd0 : load_ext(f3_p0, off_p0, mem.mem_rdata);
      end else if (timed_out) begin
        rsp_fault_p1 <= 1'b1;
        rsp_rdata_p1 <= '0;
      end else if (TIMEOUT != 0) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  assign req.req_ready      = (state == IDLE);
  assign req.rsp_valid      = (state == RESP);
  assign req.rsp_rdata      = rsp_rdata_p1;
  assign req.rsp_misaligned = rsp_mis_p1;
  assign req.rsp_fault      = rsp_fault_p1;

  assign mem.mem_req   = (state == ACCESS);
  assign mem.mem_we    = we_p0 && (state == ACCESS);
  assign mem.mem_addr  = mem_addr_p0;
  assign mem.mem_wdata = mem_wdata_p0;
  assign mem.mem_be    = mem_be_p0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a behavioural memory
// and request model; directed cases first, then random traffic.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_req_if req_bus();
  lsu_mem_if mem_bus();

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req_bus.slave),
    .mem   (mem_bus.master)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
    int          cyc;
  } rsp_t;

  rsp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  bit          exp_access = 1'b0;
  logic [31:0] exp_maddr = '0;
  logic [31:0] exp_wd = '0;
  logic [3:0]  exp_be = '0;
  logic        exp_we = 1'b0;
  int          ack_at = 0;
  int          exp_req_cyc = 0;
  logic [31:0] mem_word = '0;
  bit          aborting = 1'b0;
  bit          force_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] word,
                                             input int off);
    longint v;
    v = longint'(word >> (8 * off));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return 32'(v);
  endfunction

  // Memory model: acks in the ack_at-th request cycle, checks the bus is
  // stable while requested, and toggles a stray ack while idle.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_req) begin
        acc_cnt++;
        check("mem_req_allowed", {31'd0, mem_bus.mem_req}, {31'd0, exp_access});
        check("mem_addr",  mem_bus.mem_addr,  exp_maddr);
        check("mem_be",    {28'd0, mem_bus.mem_be}, {28'd0, exp_be});
        check("mem_we",    {31'd0, mem_bus.mem_we}, {31'd0, exp_we});
        check("mem_wdata", mem_bus.mem_wdata, exp_wd);
        mem_bus.mem_ack   = (acc_cnt == ack_at);
        mem_bus.mem_rdata = (acc_cnt == ack_at) ? mem_word : $urandom;
      end else begin
        if (acc_cnt != 0 && !aborting)
          check("mem_req_cycles", 32'(acc_cnt), 32'(exp_req_cyc));
        acc_cnt = 0;
        mem_bus.mem_ack   = force_ack || ($urandom_range(0, 1) == 1);
        mem_bus.mem_rdata = $urandom;
      end
    end
  end

  // Response monitor: every rsp_valid cycle must match the oldest expectation.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (req_bus.rsp_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required no response", cyc);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", req_bus.rsp_rdata, e.rdata);
          check("rsp_misaligned", {31'd0, req_bus.rsp_misaligned}, {31'd0, e.mis});
          check("rsp_fault", {31'd0, req_bus.rsp_fault}, {31'd0, e.fault});
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // k = ACCESS cycle in which memory acks (0 = never).
  task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] word, input int k);
    int   n, off, waited;
    bit   legal, mis, acked;
    rsp_t e;
    waited = 0;
    while (!req_bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_bus.req_ready) begin
      check("req_ready_wait", {31'd0, req_bus.req_ready}, 32'd1);
      return;
    end
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(addr % 4);
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = legal && ((addr % n) != 0);
    acked = (k >= 1) && (k <= TMO);
    exp_access  = legal && !mis;
    exp_maddr   = addr - 32'(off);
    exp_be      = 4'(((1 << n) - 1) << off);
    exp_we      = wr;
    exp_wd      = (n == 1) ? wd[7:0] * 32'h01010101 :
                  (n == 2) ? wd[15:0] * 32'h00010001 : wd;
    ack_at      = k;
    mem_word    = word;
    exp_req_cyc = acked ? k : TMO;
    e.mis   = mis;
    e.fault = !legal || (exp_access && !acked);
    e.rdata = (!exp_access || wr || e.fault) ? 32'd0 : load_model(f3, word, off);
    e.cyc   = cyc + (!exp_access ? 1 : (acked ? k + 1 : TMO + 1));
    sb_q.push_back(e);
    req_bus.req_valid  = 1'b1;
    req_bus.req_write  = wr;
    req_bus.req_funct3 = f3;
    req_bus.req_addr   = addr;
    req_bus.req_wdata  = wd;
    @(negedge clk);
    req_bus.req_valid  = 1'b0;
    req_bus.req_write  = 1'($urandom);
    req_bus.req_funct3 = 3'($urandom);
    req_bus.req_addr   = $urandom;
    req_bus.req_wdata  = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    bit          wr;
    logic [2:0]  f3;
    int          waited;
    reset = 1'b0;
    req_bus.req_valid  = 1'b0;
    req_bus.req_write  = 1'b0;
    req_bus.req_funct3 = '0;
    req_bus.req_addr   = '0;
    req_bus.req_wdata  = '0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'd0, req_bus.req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, req_bus.rsp_valid}, 32'd0);
    check("reset_rsp_flags", {30'd0, req_bus.rsp_misaligned, req_bus.rsp_fault}, 32'd0);
    check("reset_rsp_rdata", req_bus.rsp_rdata, 32'd0);
    check("reset_mem_ctl", {28'd0, mem_bus.mem_req, mem_bus.mem_we, 2'b00}, 32'd0);
    check("reset_mem_be", {28'd0, mem_bus.mem_be}, 32'd0);
    check("reset_mem_addr", mem_bus.mem_addr, 32'd0);
    check("reset_mem_wdata", mem_bus.mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(1'b0, 3'd2, 32'h40, $urandom, 32'hdeadbeef, 1);
    issue(1'b0, 3'd0, 32'h43, $urandom, 32'hcafebabe, 1);
    issue(1'b0, 3'd4, 32'h43, $urandom, 32'hcafebabe, 2);
    issue(1'b0, 3'd1, 32'h42, $urandom, 32'hcafebabe, 1);
    issue(1'b0, 3'd5, 32'h42, $urandom, 32'hcafebabe, 3);
    issue(1'b1, 3'd0, 32'h41, 32'h12345678, $urandom, 4);
    issue(1'b0, 3'd2, 32'h42, $urandom, $urandom, 1);
    issue(1'b1, 3'd1, 32'h41, $urandom, $urandom, 1);
    issue(1'b0, 3'd3, 32'h40, $urandom, $urandom, 1);
    issue(1'b1, 3'd5, 32'h40, $urandom, $urandom, 1);
    issue(1'b0, 3'd2, 32'h80, $urandom, $urandom, 0);
    issue(1'b0, 3'd2, 32'h84, $urandom, 32'h0badf00d, TMO);

    // Reset in the second ACCESS cycle of a never-acked load.
    issue(1'b0, 3'd2, 32'h100, $urandom, 32'h11111111, 0);
    @(negedge clk);
    #2;
    aborting = 1'b1;
    reset = 1'b0;
    #1;
    check("abort_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check("abort_req_ready", {31'd0, req_bus.req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, req_bus.rsp_valid}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    force_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("late_ack_quiet", {30'd0, req_bus.rsp_valid, mem_bus.mem_req}, 32'd0);
    end
    force_ack = 1'b0;
    aborting = 1'b0;

    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      issue(wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, TMO + 2));
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
